// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
// State encoding and default memory geometry.
package inst_loader_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0000;
  localparam int unsigned MAX_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/inst_loader.sv
// Streams a length-prefixed, XOR-checked program image into
// instruction memory and releases CPU reset once it verifies.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wd,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;

  logic        byte_ready_q, byte_ready_d;
  logic        im_we_q, im_we_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic [31:0] im_wd_q, im_wd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;
  logic [15:0] len_n;

  assign xfer  = byte_valid && byte_ready_q;
  assign len_n = {len_q[15:8], byte_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    unique case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_n;
          if (32'(len_n) > 32'(MAX_WORDS))
            state_d = S_ERR;
          else if (len_n == 16'd0)
            state_d = S_CSUM;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[23:0], byte_data};
          csum_d = csum_q ^ byte_data;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3)
            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // hold index on the last word so it stays below MAX_WORDS
        if (idx_q == len_q - 16'd1) begin
          state_d = S_CSUM;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (xfer)
          state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
    im_we_d      = (state_d == S_WRITE);
    im_wd_d      = im_we_d ? word_d : im_wd_q;
    im_addr_d    = BASE_ADDR + {14'd0, idx_d, 2'b00};
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_LEN_HI;
      len_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= BASE_ADDR;
      im_wd_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wd_q      <= im_wd_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wd      = im_wd_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_rst_n  = done_q;

endmodule
